forwarding_unit: RTL and testbench

- Operand-forwarding unit for the 5-stage MIPS pipeline; combines ID-stage (branch-compare) forwarding and EX-stage (ALU operand) forwarding in one block.
- Sits beside the hazard/stall logic, which keeps ownership of stalls and flushes.
- Forwarding selects are purely combinational.
- A clocked section keeps per-source forwarding event counters for performance debug.

---
 rtl/forwarding_unit.sv | 125 ++++++++++++
 tb/tb_forwarding_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/forwarding_unit.sv
// Operand-forwarding unit: ID-stage branch-compare and EX-stage ALU operand bypass selects.
// Latency: selects are combinational (0 cycles); event counters update on the rising clk edge.
// Backpressure: none; stalls and flushes stay with the hazard unit, this block only steers operands.
//
// Ports:
//   clk, reset                 : counter clock and asynchronous active-high counter reset
//   regwriteM/W, writeregM/W   : MEM/WB destination register and its write enable
//   rsD, rtD, rsE, rtE         : ID and EX source register numbers
//   cnt_en, cnt_clr            : counter enable and synchronous clear (clear wins)
//   forwardAD/BD               : 1 = ID operand takes the MEM ALU result
//   forwardAE/BE               : 00 regfile, 01 WB result, 10 MEM ALU result (11 never driven)
//   cnt_em, cnt_ew, cnt_id     : operands forwarded EX<-MEM, EX<-WB, ID<-MEM
//
// Build option: define FU_CNT_SAT_EN to make the counters saturate at all-ones;
// by default they wrap modulo 2^CNT_W.

module forwarding_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [CNT_W-1:0] cnt_em,
  output logic [CNT_W-1:0] cnt_ew,
  output logic [CNT_W-1:0] cnt_id
);

  // Source-match terms. $0 is hard-wired to zero, so a write to it is never bypassed.
  logic hit_rsd_m, hit_rtd_m;
  logic hit_rse_m, hit_rte_m;
  logic hit_rse_w, hit_rte_w;

  assign hit_rsd_m = regwriteM && (rsD != 5'd0) && (rsD == writeregM);
  assign hit_rtd_m = regwriteM && (rtD != 5'd0) && (rtD == writeregM);
  assign hit_rse_m = regwriteM && (rsE != 5'd0) && (rsE == writeregM);
  assign hit_rte_m = regwriteM && (rtE != 5'd0) && (rtE == writeregM);
  assign hit_rse_w = regwriteW && (rsE != 5'd0) && (rsE == writeregW);
  assign hit_rte_w = regwriteW && (rtE != 5'd0) && (rtE == writeregW);

  // ID only bypasses from MEM: WB data reaches ID through the split-phase regfile.
  assign forwardAD = hit_rsd_m;
  assign forwardBD = hit_rtd_m;

  // MEM is checked first so the younger result wins when both stages match.
  always_comb begin
    forwardAE = 2'b00;
    if (hit_rse_m)      forwardAE = 2'b10;
    else if (hit_rse_w) forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (hit_rte_m)      forwardBE = 2'b10;
    else if (hit_rte_w) forwardBE = 2'b01;
  end

  // Per-cycle event counts, 0..2 each.
  logic [1:0] inc_em, inc_ew, inc_id;

  assign inc_em = {1'b0, (forwardAE == 2'b10)} + {1'b0, (forwardBE == 2'b10)};
  assign inc_ew = {1'b0, (forwardAE == 2'b01)} + {1'b0, (forwardBE == 2'b01)};
  assign inc_id = {1'b0, forwardAD} + {1'b0, forwardBD};

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] cur,
                                               input logic [1:0]       inc);
`ifdef FU_CNT_SAT_EN
    logic [CNT_W:0] sum;
    // One spare bit is enough: the largest step is 2 and CNT_W >= 2.
    sum = {1'b0, cur} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) cnt_add = '1;
    else            cnt_add = sum[CNT_W-1:0];
`else
    cnt_add = cur + CNT_W'(inc);
`endif
  endfunction

  logic [CNT_W-1:0] cnt_em_q, cnt_em_d;
  logic [CNT_W-1:0] cnt_ew_q, cnt_ew_d;
  logic [CNT_W-1:0] cnt_id_q, cnt_id_d;

  always_comb begin
    cnt_em_d = cnt_em_q;
    cnt_ew_d = cnt_ew_q;
    cnt_id_d = cnt_id_q;
    if (cnt_clr) begin
      cnt_em_d = '0;
      cnt_ew_d = '0;
      cnt_id_d = '0;
    end else if (cnt_en) begin
      cnt_em_d = cnt_add(cnt_em_q, inc_em);
      cnt_ew_d = cnt_add(cnt_ew_q, inc_ew);
      cnt_id_d = cnt_add(cnt_id_q, inc_id);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_em_q <= '0;
      cnt_ew_q <= '0;
      cnt_id_q <= '0;
    end else begin
      cnt_em_q <= cnt_em_d;
      cnt_ew_q <= cnt_ew_d;
      cnt_id_q <= cnt_id_d;
    end
  end

  assign cnt_em = cnt_em_q;
  assign cnt_ew = cnt_ew_q;
  assign cnt_id = cnt_id_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed cases then randomized traffic against a rule-level model.
// Two instances share the stimulus: CNT_W = 16 and CNT_W = 2 (overflow behaviour).

module tb_forwarding_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       regwriteM = 1'b0, regwriteW = 1'b0;
  logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
  logic [4:0] writeregM = '0, writeregW = '0;
  logic       cnt_en = 1'b0, cnt_clr = 1'b0;

  logic        forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
  logic [15:0] cnt_em, cnt_ew, cnt_id;

  logic        s_forwardAD, s_forwardBD;
  logic [1:0]  s_forwardAE, s_forwardBE;
  logic [1:0]  s_cnt_em, s_cnt_ew, s_cnt_id;

  int n_cmp = 0;
  int n_err = 0;

  // Running totals of forwarded operands since the last clear/reset.
  longint tot_em = 0, tot_ew = 0, tot_id = 0;

  always #5 clk = ~clk;

  forwarding_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .regwriteM(regwriteM), .regwriteW(regwriteW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregM(writeregM), .writeregW(writeregW),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .cnt_em(cnt_em), .cnt_ew(cnt_ew), .cnt_id(cnt_id)
  );

  forwarding_unit #(.CNT_W(2)) u_dut_small (
    .clk(clk), .reset(reset),
    .regwriteM(regwriteM), .regwriteW(regwriteW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregM(writeregM), .writeregW(writeregW),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .forwardAD(s_forwardAD), .forwardBD(s_forwardBD),
    .forwardAE(s_forwardAE), .forwardBE(s_forwardBE),
    .cnt_em(s_cnt_em), .cnt_ew(s_cnt_ew), .cnt_id(s_cnt_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: the forwarding rules written out directly ----
  function automatic int ex_src(input int r, input int wm, input bit rwm, input int ww, input bit rww);
    if (r == 0)                 return 0;   // register file
    if (rwm && r == wm)         return 2;   // MEM, youngest
    if (rww && r == ww)         return 1;   // WB
    return 0;
  endfunction

  function automatic int id_src(input int r, input int wm, input bit rwm);
    return (r != 0 && rwm && r == wm) ? 1 : 0;
  endfunction

  function automatic longint cnt_view(input longint tot, input int w);
    longint span;
    span = longint'(1) << w;
`ifdef FU_CNT_SAT_EN
    return (tot > span - 1) ? span - 1 : tot;
`else
    return tot % span;
`endif
  endfunction

  task automatic set_in(input int rsd, input int rtd, input int rse, input int rte,
                        input int wm, input bit rwm, input int ww, input bit rww);
    rsD = 5'(rsd); rtD = 5'(rtd); rsE = 5'(rse); rtE = 5'(rte);
    writeregM = 5'(wm); regwriteM = rwm; writeregW = 5'(ww); regwriteW = rww;
  endtask

  task automatic check_fwd();
    int ae, be, ad, bd;
    ae = ex_src(rsE, writeregM, regwriteM, writeregW, regwriteW);
    be = ex_src(rtE, writeregM, regwriteM, writeregW, regwriteW);
    ad = id_src(rsD, writeregM, regwriteM);
    bd = id_src(rtD, writeregM, regwriteM);
    check("forwardAE", 32'(forwardAE), 32'(ae));
    check("forwardBE", 32'(forwardBE), 32'(be));
    check("forwardAD", 32'(forwardAD), 32'(ad));
    check("forwardBD", 32'(forwardBD), 32'(bd));
  endtask

  task automatic check_cnt();
    check("cnt_em",   32'(cnt_em),   32'(cnt_view(tot_em, 16)));
    check("cnt_ew",   32'(cnt_ew),   32'(cnt_view(tot_ew, 16)));
    check("cnt_id",   32'(cnt_id),   32'(cnt_view(tot_id, 16)));
    check("s_cnt_em", 32'(s_cnt_em), 32'(cnt_view(tot_em, 2)));
    check("s_cnt_ew", 32'(s_cnt_ew), 32'(cnt_view(tot_ew, 2)));
    check("s_cnt_id", 32'(s_cnt_id), 32'(cnt_view(tot_id, 2)));
  endtask

  // Inputs already applied: check selects, clock once, fold the cycle into the model, check counters.
  task automatic cycle(input bit en, input bit clr);
    int ae, be, ad, bd;
    cnt_en = en; cnt_clr = clr;
    #1;
    check_fwd();
    ae = ex_src(rsE, writeregM, regwriteM, writeregW, regwriteW);
    be = ex_src(rtE, writeregM, regwriteM, writeregW, regwriteW);
    ad = id_src(rsD, writeregM, regwriteM);
    bd = id_src(rtD, writeregM, regwriteM);
    @(posedge clk);
    if (clr) begin
      tot_em = 0; tot_ew = 0; tot_id = 0;
    end else if (en) begin
      tot_em += (ae == 2 ? 1 : 0) + (be == 2 ? 1 : 0);
      tot_ew += (ae == 1 ? 1 : 0) + (be == 1 ? 1 : 0);
      tot_id += ad + bd;
    end
    #1;
    check_cnt();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    #3;
    check_cnt();
    @(posedge clk); #1;
    reset = 1'b0;
    check_cnt();

    // Both EX operands match MEM and WB: MEM wins, two MEM events.
    set_in(0, 0, 5, 5, 5, 1, 5, 1);
    cycle(1, 0);
    check("plan_em_2", 32'(cnt_em), 32'd2);
    check("plan_ew_0", 32'(cnt_ew), 32'd0);

    // Small counter sits at 2; another double-MEM cycle overflows it.
    cycle(1, 0);
`ifdef FU_CNT_SAT_EN
    check("small_ovf", 32'(s_cnt_em), 32'd3);
`else
    check("small_ovf", 32'(s_cnt_em), 32'd0);
`endif

    // rsE misses, rtE from WB.
    set_in(0, 0, 3, 7, 9, 1, 7, 1);
    cycle(1, 0);
    check("plan_BE_wb", 32'(forwardBE), 32'd1);

    // Writes to $0 never forward.
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    cycle(1, 0);

    // ID match without regwriteM, then with it.
    set_in(4, 4, 0, 0, 4, 0, 0, 0);
    cycle(1, 0);
    set_in(4, 4, 0, 0, 4, 1, 0, 0);
    cycle(1, 0);
    check("plan_id_2", 32'(cnt_id), 32'd2);
    cycle(0, 0);   // disabled: hold

    // Clear together with enable.
    set_in(6, 6, 6, 6, 6, 1, 6, 1);
    cycle(1, 1);
    check("plan_clr", 32'(cnt_em), 32'd0);
    cycle(1, 0);

    // Reset mid-count, away from the edge.
    #2;
    reset = 1'b1;
    #1;
    tot_em = 0; tot_ew = 0; tot_id = 0;
    check_cnt();
    check_fwd();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic; small register range to provoke frequent matches.
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
